// File: rtl/ft245_bus_ctrl.sv
// FT245-style USB-FIFO bus sequencer: arbitrates TX/RX transfers on the shared
// 8-bit bus, times rd/wr strobes and output enable, and buffers bytes each side.
module ft245_bus_ctrl #(
   parameter int FIFO_AW  = 2,
   parameter int RD_PULSE = 4,
   parameter int WR_SETUP = 1,
   parameter int WR_PULSE = 4,
   parameter int GAP      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] bus_din,
   output logic [7:0] bus_dout,
   output logic       bus_oe,
   output logic       bus_rd_n,
   output logic       bus_wr_n,
   input  logic       txe_n,
   input  logic       rxf_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = 8;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
   localparam logic [CW-1:0] RD_LOAD  = CW'(RD_PULSE - 1);
   localparam logic [CW-1:0] WS_LOAD  = CW'(WR_SETUP - 1);
   localparam logic [CW-1:0] WR_LOAD  = CW'(WR_PULSE - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

   typedef enum logic [2:0] {IDLE, RD, WS, WR, WH, RECOV} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            lastWasRx_q;
   logic            rxPush_q;
   logic [7:0]      rxByte_q;

   logic [7:0]       txMem_q [DEPTH];
   logic [FIFO_AW:0] txWptr_q, txRptr_q, txWptr_d, txRptr_d, txCount_d;
   logic             txPush, txPop, txPopNext;
   logic [7:0]       txHead;

   logic [7:0]       rxMem_q [DEPTH];
   logic [FIFO_AW:0] rxWptr_q, rxRptr_q, rxWptr_d, rxRptr_d, rxCount_d, rxFill;
   logic             rxPop;

   logic rdOk, wrOk;

   assign rxFill = rxWptr_q - rxRptr_q;
   assign rdOk   = !rxf_n && (rxFill != FULL_CNT);
   assign wrOk   = !txe_n && (txWptr_q != txRptr_q);

   // FSM owns strobes, oe and write data; all of them leave as flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bus_rd_n    <= 1'b1;
         bus_wr_n    <= 1'b1;
         bus_oe      <= 1'b0;
         bus_dout    <= '0;
         lastWasRx_q <= 1'b0;
         busy        <= 1'b0;
         rxPush_q    <= 1'b0;
         rxByte_q    <= '0;
      end else begin
         rxPush_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rdOk && (!wrOk || !lastWasRx_q)) begin
                  state_q     <= RD;
                  bus_rd_n    <= 1'b0;
                  cnt_q       <= RD_LOAD;
                  lastWasRx_q <= 1'b1;
                  busy        <= 1'b1;
               end else if (wrOk) begin
                  state_q     <= WS;
                  bus_oe      <= 1'b1;
                  bus_dout    <= txHead;
                  cnt_q       <= WS_LOAD;
                  lastWasRx_q <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            RD: begin
               if (cnt_q == '0) begin
                  rxByte_q <= bus_din;
                  rxPush_q <= 1'b1;
                  bus_rd_n <= 1'b1;
                  cnt_q    <= GAP_LOAD;
                  state_q  <= RECOV;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            WS: begin
               if (cnt_q == '0) begin
                  bus_wr_n <= 1'b0;
                  cnt_q    <= WR_LOAD;
                  state_q  <= WR;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            WR: begin
               if (cnt_q == '0) begin
                  bus_wr_n <= 1'b1;
                  state_q  <= WH;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            WH: begin
               bus_oe  <= 1'b0;
               cnt_q   <= GAP_LOAD;
               state_q <= RECOV;
            end
            RECOV: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // TX pop is known a cycle early, so a full FIFO can still offer ready for that cycle.
   assign txPush    = tx_valid & tx_ready;
   assign txPop     = (state_q == WR) && (cnt_q == '0);
   assign txPopNext = ((state_q == WR) && (cnt_q == CW'(1))) ||
                      ((state_q == WS) && (cnt_q == '0) && (WR_PULSE == 1));
   assign txWptr_d  = txWptr_q + {{FIFO_AW{1'b0}}, txPush};
   assign txRptr_d  = txRptr_q + {{FIFO_AW{1'b0}}, txPop};
   assign txCount_d = txWptr_d - txRptr_d;
   assign txHead    = txMem_q[txRptr_q[FIFO_AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         txWptr_q <= '0;
         txRptr_q <= '0;
         tx_ready <= 1'b1;
      end else begin
         if (txPush) txMem_q[txWptr_q[FIFO_AW-1:0]] <= tx_data;
         txWptr_q <= txWptr_d;
         txRptr_q <= txRptr_d;
         tx_ready <= (txCount_d != FULL_CNT) || txPopNext;
      end
   end

   // RX head is re-registered each cycle, bypassing the byte being written into an empty FIFO.
   assign rxPop     = rx_valid & rx_ready;
   assign rxWptr_d  = rxWptr_q + {{FIFO_AW{1'b0}}, rxPush_q};
   assign rxRptr_d  = rxRptr_q + {{FIFO_AW{1'b0}}, rxPop};
   assign rxCount_d = rxWptr_d - rxRptr_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxWptr_q <= '0;
         rxRptr_q <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         if (rxPush_q) rxMem_q[rxWptr_q[FIFO_AW-1:0]] <= rxByte_q;
         rxWptr_q <= rxWptr_d;
         rxRptr_q <= rxRptr_d;
         rx_valid <= (rxCount_d != '0);
         if (rxCount_d != '0) begin
            if (rxPush_q && (rxRptr_d == rxWptr_q)) rx_data <= rxByte_q;
            else rx_data <= rxMem_q[rxRptr_d[FIFO_AW-1:0]];
         end
      end
   end

endmodule

// File: tb/tb_ft245_bus_ctrl.sv
// Directed bench for ft245_bus_ctrl: reset, single read/write timing,
// arbitration, FIFO full behaviour and reset during a write.
module tb_ft245_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] bus_din = 8'h00;
   logic [7:0] bus_dout;
   logic       bus_oe, bus_rd_n, bus_wr_n;
   logic       txe_n = 1'b1;
   logic       rxf_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       busy;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   ft245_bus_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus_din  (bus_din),
      .bus_dout (bus_dout),
      .bus_oe   (bus_oe),
      .bus_rd_n (bus_rd_n),
      .bus_wr_n (bus_wr_n),
      .txe_n    (txe_n),
      .rxf_n    (rxf_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .busy     (busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rxfN, input logic txeN, input logic rxRdy);
      rxf_n    = rxfN;
      txe_n    = txeN;
      rx_ready = rxRdy;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bus invariants hold on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("inv rd_wr", 32'(bus_rd_n | bus_wr_n), 32'd1);
         checkOutput("inv oe_rd", 32'(!(bus_oe && !bus_rd_n)), 32'd1);
      end
   end

   initial begin
      int         starts, idle, rdFalls, strobes;
      logic       prevRd, prevOe, found;
      logic       kinds [4];
      logic [7:0] douts [4];
      int         gaps  [4];

      // T1: reset with both flags asserted
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(3);
      checkOutput("T1 rd_n", 32'(bus_rd_n), 32'd1);
      checkOutput("T1 wr_n", 32'(bus_wr_n), 32'd1);
      checkOutput("T1 oe", 32'(bus_oe), 32'd0);
      checkOutput("T1 dout", 32'(bus_dout), 32'd0);
      checkOutput("T1 tx_ready", 32'(tx_ready), 32'd1);
      checkOutput("T1 rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("T1 busy", 32'(busy), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      tick(2);
      checkOutput("T1 idle busy", 32'(busy), 32'd0);

      // T2: single read of 0xA5
      applyStimulus(1'b0, 1'b1, 1'b0);
      bus_din = 8'hA5;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checkOutput($sformatf("T2 rd_n c%0d", i), 32'(bus_rd_n), (i <= 4) ? 32'd0 : 32'd1);
         checkOutput($sformatf("T2 rx_valid c%0d", i), 32'(rx_valid), (i >= 6) ? 32'd1 : 32'd0);
         if (i == 1) applyStimulus(1'b1, 1'b1, 1'b0);
      end
      checkOutput("T2 rx_data", 32'(rx_data), 32'hA5);
      checkOutput("T2 busy done", 32'(busy), 32'd0);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      checkOutput("T2 rx_valid popped", 32'(rx_valid), 32'd0);

      // T3: single write of 0x3C
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      checkOutput("T3 tx_ready", 32'(tx_ready), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         checkOutput($sformatf("T3 oe c%0d", i), 32'(bus_oe), (i <= 6) ? 32'd1 : 32'd0);
         checkOutput($sformatf("T3 wr_n c%0d", i), 32'(bus_wr_n), (i >= 2 && i <= 5) ? 32'd0 : 32'd1);
         if (i <= 6) checkOutput($sformatf("T3 dout c%0d", i), 32'(bus_dout), 32'h3C);
         if (i == 1) applyStimulus(1'b1, 1'b1, 1'b0);
      end
      tick(1);
      checkOutput("T3 busy done", 32'(busy), 32'd0);

      // T4: contention, RX wins the first tie then grants alternate
      tx_valid = 1'b1;
      tx_data  = 8'h11;
      tick(1);
      tx_data  = 8'h22;
      tick(1);
      tx_valid = 1'b0;
      bus_din  = 8'h77;
      applyStimulus(1'b0, 1'b0, 1'b1);
      prevRd = 1'b1;
      prevOe = 1'b0;
      idle   = 0;
      starts = 0;
      for (int c = 0; c < 200 && starts < 4; c++) begin
         @(negedge clk);
         if ((prevRd && !bus_rd_n) || (!prevOe && bus_oe)) begin
            kinds[starts] = !bus_rd_n;
            douts[starts] = bus_dout;
            gaps[starts]  = idle;
            starts++;
         end
         if (bus_rd_n && bus_wr_n && !bus_oe) idle++;
         else idle = 0;
         prevRd = bus_rd_n;
         prevOe = bus_oe;
      end
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("T4 starts", 32'(starts), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < starts) begin
            checkOutput($sformatf("T4 kind%0d", k), 32'(kinds[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 1)
               checkOutput($sformatf("T4 dout%0d", k), 32'(douts[k]), (k == 1) ? 32'h11 : 32'h22);
            if (k >= 1)
               checkOutput($sformatf("T4 gap%0d", k), 32'(gaps[k] >= 3), 32'd1);
         end
      end
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         if (!busy) found = 1'b1;
      end
      checkOutput("T4 settle", 32'(found), 32'd1);
      tick(2);
      rx_ready = 1'b0;
      checkOutput("T4 rx drained", 32'(rx_valid), 32'd0);

      // T5a: RX FIFO fills with rx_ready low, then reads stop
      applyStimulus(1'b0, 1'b1, 1'b0);
      rdFalls = 0;
      prevRd  = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (prevRd && !bus_rd_n) begin
            rdFalls++;
            bus_din = 8'(8'h40 + rdFalls);
         end
         prevRd = bus_rd_n;
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("T5 read count", 32'(rdFalls), 32'd4);
      checkOutput("T5 busy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("T5 rx_valid%0d", k), 32'(rx_valid), 32'd1);
         checkOutput($sformatf("T5 rx_data%0d", k), 32'(rx_data), 32'(8'h41 + k));
         rx_ready = 1'b1;
         tick(1);
      end
      rx_ready = 1'b0;
      checkOutput("T5 rx empty", 32'(rx_valid), 32'd0);

      // T5b: TX FIFO fills with txe_n high
      for (int j = 0; j < 5; j++) begin
         tx_data  = 8'(8'hA0 + j);
         tx_valid = 1'b1;
         checkOutput($sformatf("T5 tx_ready%0d", j), 32'(tx_ready), (j < 4) ? 32'd1 : 32'd0);
         tick(1);
      end
      tx_valid = 1'b0;
      checkOutput("T5 tx full", 32'(tx_ready), 32'd0);

      // T6: reset asserted while wr_n is low
      applyStimulus(1'b1, 1'b0, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (!bus_wr_n) found = 1'b1;
      end
      checkOutput("T6 wr seen", 32'(found), 32'd1);
      checkOutput("T6 dout", 32'(bus_dout), 32'hA0);
      rst_n = 1'b0;
      tick(1);
      checkOutput("T6 wr_n", 32'(bus_wr_n), 32'd1);
      checkOutput("T6 oe", 32'(bus_oe), 32'd0);
      checkOutput("T6 busy", 32'(busy), 32'd0);
      checkOutput("T6 tx_ready", 32'(tx_ready), 32'd1);
      rst_n   = 1'b1;
      strobes = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!bus_wr_n || !bus_rd_n || bus_oe) strobes++;
      end
      checkOutput("T6 no strobes", 32'(strobes), 32'd0);
      checkOutput("T6 tx empty", 32'(tx_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
